// File: rtl/ctrl_general_multi.sv
// ctrl_general_multi: general-control FSM for the RTC clock/alarm/chronometer
// system. Registers the programming requests, status sources, RTC-init request
// and alarm match, keeps sticky status flags with an acknowledge, and decodes
// {prog_any, stat_any, init} into the 2-bit global mode
// (I=00, L=01, E=10, M_S=11) with a one-hot programming grant in E.
// Optional feature macro: STATUS_TIMEOUT_EN (status auto-clear after TMO_CYC
// cycles in M_S without acknowledge; tmo_flag tied low when undefined).
module ctrl_general_multi #(
  parameter int NUM_PROG  = 3,
  parameter int NUM_STAT  = 3,
  parameter int ALARM_W   = 24,
  parameter int CRONO_IDX = 2,
  parameter int TMO_W     = 16,
  parameter int TMO_CYC   = 50000
) (
  input  logic                reloj,
  input  logic                resetM,
  input  logic [NUM_PROG-1:0] prog_req,
  input  logic [NUM_STAT-1:0] status_src,
  input  logic [NUM_STAT-1:0] status_mask,
  input  logic [ALARM_W-1:0]  alarma,
  input  logic                r_rtc,
  input  logic                status_ack,
  output logic [1:0]          control,
  output logic [NUM_PROG-1:0] prog_grant,
  output logic [NUM_STAT-1:0] status_vec,
  output logic                act_crono,
  output logic                tmo_flag
);

  typedef enum logic [1:0] {
    ST_I  = 2'b00,
    ST_L  = 2'b01,
    ST_E  = 2'b10,
    ST_MS = 2'b11
  } state_t;

  // The timeout counter must be able to hold TMO_CYC-1.
  if (TMO_CYC >= (1 << TMO_W)) begin : g_bad_tmo
    $error("TMO_CYC must be below 2**TMO_W");
  end

  logic [NUM_PROG-1:0] prog_req_q;
  logic [NUM_STAT-1:0] status_src_q;
  logic                r_rtc_q;
  logic                alarm_any_q;
  logic                act_crono_q;
  logic [NUM_STAT-1:0] src_prev_q;
  logic [NUM_STAT-1:0] status_vec_q, status_vec_d;
  logic [2:0]          psi_q, psi_d;
  state_t              state_q, state_d, decode_s;
  logic [NUM_PROG-1:0] grant_q, grant_d;
  logic [NUM_STAT-1:0] src_eff_s;
  logic [NUM_STAT-1:0] edge_s;
  logic                tmo_fire_s;

  // Lowest-index set bit of a request vector, as a one-hot value.
  function automatic logic [NUM_PROG-1:0] lowest_one(input logic [NUM_PROG-1:0] v);
    logic [NUM_PROG-1:0] r;
    logic                found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PROG; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Input stage: single registration of every level input plus the alarm OR.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      prog_req_q   <= '0;
      status_src_q <= '0;
      r_rtc_q      <= 1'b0;
      alarm_any_q  <= 1'b0;
    end else begin
      prog_req_q   <= prog_req;
      status_src_q <= status_src;
      r_rtc_q      <= r_rtc;
      alarm_any_q  <= |alarma;
    end
  end

  // Effective status sources (act_crono folded into the top source) and masked rising edges.
  always_comb begin
    src_eff_s                = status_src_q;
    src_eff_s[NUM_STAT-1]    = status_src_q[NUM_STAT-1] | act_crono_q;
    edge_s                   = src_eff_s & ~src_prev_q & status_mask;
    // A new edge wins over ack/timeout for its own bit only.
    if (status_ack || tmo_fire_s) begin
      status_vec_d = edge_s;
    end else begin
      status_vec_d = status_vec_q | edge_s;
    end
    psi_d = {|prog_req_q, |status_vec_q, r_rtc_q};
  end

  // Edge-detector history, sticky flags, chronometer activation and decode register.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      src_prev_q   <= '0;
      status_vec_q <= '0;
      act_crono_q  <= 1'b0;
      psi_q        <= 3'b000;
    end else begin
      src_prev_q   <= src_eff_s;
      status_vec_q <= status_vec_d;
      act_crono_q  <= alarm_any_q & ~prog_req_q[CRONO_IDX];
      psi_q        <= psi_d;
    end
  end

  // Next-state decode from PSI only, plus the programming-grant arbitration.
  always_comb begin
    decode_s = ST_L;
    if (psi_q[0]) begin
      decode_s = ST_I;
    end else if (psi_q[1]) begin
      decode_s = ST_MS;
    end else if (psi_q[2]) begin
      decode_s = ST_E;
    end else begin
      decode_s = ST_L;
    end

    // A corrupted state register is steered back to L.
    case (state_q)
      ST_I, ST_L, ST_E, ST_MS: state_d = decode_s;
      default:                 state_d = ST_L;
    endcase

    grant_d = '0;
    if (state_d == ST_E) begin
      if ((state_q == ST_E) && (|(grant_q & prog_req_q))) begin
        grant_d = grant_q;
      end else begin
        grant_d = lowest_one(prog_req_q);
      end
    end else begin
      grant_d = '0;
    end
  end

  // Mode register and grant register; the grant drops together with leaving E.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q <= ST_I;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef STATUS_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q;

  // Timeout counter: counts cycles in M_S, restarts on entry, ack, expiry or exit.
  always_comb begin
    tmo_fire_s = (state_q == ST_MS) && !status_ack && (cnt_q == TMO_W'(TMO_CYC - 1));
    if ((state_q != ST_MS) || (state_d != ST_MS) || status_ack || tmo_fire_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  // Counter and one-cycle timeout pulse registers.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_fire_s;
    end
  end

  assign tmo_flag = tmo_q;
`else
  assign tmo_fire_s = 1'b0;
  assign tmo_flag   = 1'b0;
`endif

  assign control    = state_q;
  assign prog_grant = grant_q;
  assign status_vec = status_vec_q;
  assign act_crono  = act_crono_q;

endmodule

// File: tb/tb_ctrl_general_multi.sv
// Directed bench for ctrl_general_multi; expected values hand-derived from the
// pipeline depths (3 clocks input->mode, 2 clocks status edge->flag).
module tb_ctrl_general_multi;

  logic        reloj;
  logic        resetM;
  logic [2:0]  prog_req;
  logic [2:0]  status_src;
  logic [2:0]  status_mask;
  logic [23:0] alarma;
  logic        r_rtc;
  logic        status_ack;
  logic [1:0]  control;
  logic [2:0]  prog_grant;
  logic [2:0]  status_vec;
  logic        act_crono;
  logic        tmo_flag;

  int n_tests = 0;
  int n_fail  = 0;

  ctrl_general_multi #(
    .NUM_PROG(3), .NUM_STAT(3), .ALARM_W(24), .CRONO_IDX(2),
    .TMO_W(16), .TMO_CYC(8)
  ) dut (
    .reloj(reloj), .resetM(resetM), .prog_req(prog_req),
    .status_src(status_src), .status_mask(status_mask), .alarma(alarma),
    .r_rtc(r_rtc), .status_ack(status_ack), .control(control),
    .prog_grant(prog_grant), .status_vec(status_vec),
    .act_crono(act_crono), .tmo_flag(tmo_flag)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge reloj);
    #1;
  endtask

  initial begin
    resetM = 1'b1; prog_req = 3'b000; status_src = 3'b000; status_mask = 3'b111;
    alarma = 24'h000000; r_rtc = 1'b0; status_ack = 1'b0;

    // Reset state
    tick(3);
    check_eq("rst_control", 32'(control), 32'h0);
    check_eq("rst_grant", 32'(prog_grant), 32'h0);
    check_eq("rst_status", 32'(status_vec), 32'h0);
    check_eq("rst_act", 32'(act_crono), 32'h0);
    check_eq("rst_tmo", 32'(tmo_flag), 32'h0);
    resetM = 1'b0;
    tick(3);
    check_eq("idle_control", 32'(control), 32'h1);
    check_eq("idle_grant", 32'(prog_grant), 32'h0);

    // Programming request and grant arbitration
    prog_req = 3'b110;
    tick(2);
    check_eq("prog_lat2", 32'(control), 32'h1);
    tick(1);
    check_eq("prog_control", 32'(control), 32'h2);
    check_eq("prog_grant", 32'(prog_grant), 32'h2);
    prog_req = 3'b100;
    tick(1);
    check_eq("rearb_wait", 32'(prog_grant), 32'h2);
    tick(1);
    check_eq("rearb_grant", 32'(prog_grant), 32'h4);
    check_eq("rearb_control", 32'(control), 32'h2);
    prog_req = 3'b101;
    tick(3);
    check_eq("hold_grant", 32'(prog_grant), 32'h4);
    prog_req = 3'b000;
    tick(3);
    check_eq("drop_control", 32'(control), 32'h1);
    check_eq("drop_grant", 32'(prog_grant), 32'h0);

    // Status pre-empts programming; ack returns to E
    prog_req = 3'b110;
    tick(3);
    check_eq("e2_grant", 32'(prog_grant), 32'h2);
    status_src = 3'b001;
    tick(1);
    status_src = 3'b000;
    tick(1);
    check_eq("stat_set", 32'(status_vec), 32'h1);
    check_eq("stat_still_e", 32'(control), 32'h2);
    tick(2);
    check_eq("ms_control", 32'(control), 32'h3);
    check_eq("ms_grant", 32'(prog_grant), 32'h0);
    status_ack = 1'b1;
    tick(1);
    status_ack = 1'b0;
    check_eq("ack_clear", 32'(status_vec), 32'h0);
    tick(2);
    check_eq("back_e", 32'(control), 32'h2);
    check_eq("back_e_grant", 32'(prog_grant), 32'h2);

    // Held source does not re-set after ack
    status_src = 3'b010;
    tick(2);
    check_eq("held_set", 32'(status_vec), 32'h2);
    status_ack = 1'b1;
    tick(1);
    status_ack = 1'b0;
    tick(3);
    check_eq("held_no_reset", 32'(status_vec), 32'h0);
    status_src = 3'b000;
    tick(1);

    // Masked source is ignored
    status_mask = 3'b101;
    status_src  = 3'b010;
    tick(1);
    status_src = 3'b000;
    tick(3);
    check_eq("masked", 32'(status_vec), 32'h0);
    status_mask = 3'b111;

    // Set wins over ack in the same cycle
    status_src = 3'b001;
    tick(1);
    status_ack = 1'b1;
    tick(1);
    status_ack = 1'b0;
    check_eq("set_over_ack", 32'(status_vec), 32'h1);
    status_ack = 1'b1;
    status_src = 3'b000;
    tick(1);
    status_ack = 1'b0;
    check_eq("ack_after", 32'(status_vec), 32'h0);
    tick(3);
    check_eq("e3_control", 32'(control), 32'h2);

    // Alarm-driven chronometer activation
    prog_req = 3'b000;
    alarma   = 24'h000400;
    tick(2);
    check_eq("act_on", 32'(act_crono), 32'h1);
    tick(1);
    check_eq("act_status", 32'(status_vec), 32'h4);
    prog_req = 3'b100;
    tick(2);
    check_eq("act_off", 32'(act_crono), 32'h0);
    alarma = 24'h000000;
    status_ack = 1'b1;
    tick(1);
    status_ack = 1'b0;
    check_eq("act_ack", 32'(status_vec), 32'h0);

    // RTC init overrides everything
    prog_req   = 3'b001;
    status_src = 3'b011;
    tick(1);
    status_src = 3'b000;
    tick(1);
    check_eq("init_stat", 32'(status_vec), 32'h3);
    tick(2);
    check_eq("init_pre_ms", 32'(control), 32'h3);
    r_rtc = 1'b1;
    tick(3);
    check_eq("init_control", 32'(control), 32'h0);
    check_eq("init_grant", 32'(prog_grant), 32'h0);
    tick(2);
    check_eq("init_held", 32'(control), 32'h0);
    r_rtc = 1'b0;
    tick(3);
    check_eq("init_release", 32'(control), 32'h3);
    check_eq("init_keep_stat", 32'(status_vec), 32'h3);

    // Status timeout (or indefinite M_S without the feature)
    status_ack = 1'b1;
    tick(1);
    status_ack = 1'b0;
    check_eq("pre_tmo_clear", 32'(status_vec), 32'h0);
    prog_req = 3'b000;
    tick(4);
    check_eq("pre_tmo_idle", 32'(control), 32'h1);
    status_src = 3'b001;
    tick(1);
    status_src = 3'b000;
    tick(3);
    check_eq("tmo_ms", 32'(control), 32'h3);
`ifdef STATUS_TIMEOUT_EN
    tick(7);
    check_eq("tmo_early", 32'(tmo_flag), 32'h0);
    tick(1);
    check_eq("tmo_pulse", 32'(tmo_flag), 32'h1);
    check_eq("tmo_clear", 32'(status_vec), 32'h0);
    tick(1);
    check_eq("tmo_pulse_end", 32'(tmo_flag), 32'h0);
    tick(1);
    check_eq("tmo_exit", 32'(control), 32'h1);
`else
    tick(110);
    check_eq("no_tmo_ms", 32'(control), 32'h3);
    check_eq("no_tmo_flag", 32'(tmo_flag), 32'h0);
    check_eq("no_tmo_stat", 32'(status_vec), 32'h1);
`endif

    // Mid-operation reset
    prog_req = 3'b010;
    resetM   = 1'b1;
    tick(1);
    check_eq("mid_rst_control", 32'(control), 32'h0);
    check_eq("mid_rst_stat", 32'(status_vec), 32'h0);
    check_eq("mid_rst_grant", 32'(prog_grant), 32'h0);
    resetM   = 1'b0;
    prog_req = 3'b000;
    tick(3);
    check_eq("mid_rst_idle", 32'(control), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
